// File: rtl/fp_accumulate_driver.sv
// Accumulates LEN single-precision samples by driving an external stb/ack adder,
// then hands the frame total to a downstream consumer on its own stb/ack port.
module fp_accumulate_driver #(
    parameter int unsigned LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_x,
    input  logic        input_x_stb,
    output logic        input_x_ack,
    output logic [31:0] adder_a,
    output logic        adder_a_stb,
    input  logic        adder_a_ack,
    output logic [31:0] adder_b,
    output logic        adder_b_stb,
    input  logic        adder_b_ack,
    input  logic [31:0] adder_z,
    input  logic        adder_z_stb,
    output logic        adder_z_ack,
    output logic [31:0] output_sum,
    output logic        output_sum_stb,
    input  logic        output_sum_ack
);

    localparam logic [15:0] LEN16 = 16'(LEN);

    typedef enum logic [2:0] {
        ST_GET_X   = 3'd0,
        ST_PUT_A   = 3'd1,
        ST_PUT_B   = 3'd2,
        ST_GET_Z   = 3'd3,
        ST_PUT_SUM = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_acc;
    logic [31:0] r_x;
    logic [15:0] r_count;

    // Frame sequencer: one handshake per state, every stb/ack driven from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_GET_X;
            r_acc          <= 32'h0000_0000;
            r_x            <= 32'h0000_0000;
            r_count        <= 16'd0;
            input_x_ack    <= 1'b0;
            adder_a        <= 32'h0000_0000;
            adder_a_stb    <= 1'b0;
            adder_b        <= 32'h0000_0000;
            adder_b_stb    <= 1'b0;
            adder_z_ack    <= 1'b0;
            output_sum     <= 32'h0000_0000;
            output_sum_stb <= 1'b0;
        end else begin
            case (r_state)
                ST_GET_X: begin
                    input_x_ack <= 1'b1;
                    if (input_x_stb && input_x_ack) begin
                        r_x         <= input_x;
                        input_x_ack <= 1'b0;
                        r_state     <= ST_PUT_A;
                    end
                end
                ST_PUT_A: begin
                    adder_a     <= r_acc;
                    adder_a_stb <= 1'b1;
                    if (adder_a_stb && adder_a_ack) begin
                        adder_a_stb <= 1'b0;
                        r_state     <= ST_PUT_B;
                    end
                end
                ST_PUT_B: begin
                    adder_b     <= r_x;
                    adder_b_stb <= 1'b1;
                    if (adder_b_stb && adder_b_ack) begin
                        adder_b_stb <= 1'b0;
                        r_state     <= ST_GET_Z;
                    end
                end
                ST_GET_Z: begin
                    adder_z_ack <= 1'b1;
                    if (adder_z_stb && adder_z_ack) begin
                        r_acc       <= adder_z;
                        r_count     <= r_count + 16'd1;
                        adder_z_ack <= 1'b0;
                        // The sample just summed closes the frame when count reaches LEN.
                        if (r_count + 16'd1 == LEN16) begin
                            r_state <= ST_PUT_SUM;
                        end else begin
                            r_state <= ST_GET_X;
                        end
                    end
                end
                ST_PUT_SUM: begin
                    output_sum     <= r_acc;
                    output_sum_stb <= 1'b1;
                    if (output_sum_stb && output_sum_ack) begin
                        output_sum_stb <= 1'b0;
                        r_acc          <= 32'h0000_0000;
                        r_count        <= 16'd0;
                        r_state        <= ST_GET_X;
                    end
                end
                default: begin
                    r_state <= ST_GET_X;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulate_driver.sv
// Randomised bench: emulates the adder and both stream peers, predicts every
// adder operand and frame total from a real-arithmetic model of the sample stream.
module tb_fp_accumulate_driver;

    localparam int LEN = 4;
    localparam logic [31:0] QNAN = 32'hffc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_x;
    logic        input_x_stb;
    logic        input_x_ack;
    logic [31:0] adder_a;
    logic        adder_a_stb;
    logic        adder_a_ack;
    logic [31:0] adder_b;
    logic        adder_b_stb;
    logic        adder_b_ack;
    logic [31:0] adder_z;
    logic        adder_z_stb;
    logic        adder_z_ack;
    logic [31:0] output_sum;
    logic        output_sum_stb;
    logic        output_sum_ack;

    always #5 clk = ~clk;

    fp_accumulate_driver #(.LEN(LEN)) dut (
        .clk(clk), .rst(rst),
        .input_x(input_x), .input_x_stb(input_x_stb), .input_x_ack(input_x_ack),
        .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
        .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
        .output_sum(output_sum), .output_sum_stb(output_sum_stb),
        .output_sum_ack(output_sum_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // model of the sample stream
    logic [31:0] feed_q[$];
    logic [31:0] op_a_q[$];
    logic [31:0] op_b_q[$];
    logic [31:0] exp_out_q[$];
    logic [31:0] lit_q[$];
    logic [31:0] lit_a_q[$];
    real         m_sum = 0.0;
    bit          m_nan = 1'b0;
    int          m_n = 0;
    int          n_out = 0;

    // adder emulation and peer control
    bit          em_have_z = 1'b0;
    logic [31:0] em_a, em_z;
    int          em_lat = 0;
    int          hold_out = 0;
    bit          rst_req = 1'b0;
    bit          rst_check = 1'b0;

    // previous-cycle view for hold-stable checks
    bit          p_valid = 1'b0;
    bit          p_a_stb, p_b_stb, p_o_stb, p_t_a, p_t_b, p_t_o;
    logic [31:0] p_a, p_b, p_o;

    function automatic bit is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hff) && (f[22:0] != 23'd0);
    endfunction

    // Normal numbers and zero only; that is all the stimulus produces.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0000_0000;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit t_x, t_a, t_b, t_z, t_o, saw_rst;
        @(negedge clk);
        saw_rst = rst;
        t_x = !rst && input_x_stb && input_x_ack;
        t_a = !rst && adder_a_stb && adder_a_ack;
        t_b = !rst && adder_b_stb && adder_b_ack;
        t_z = !rst && adder_z_stb && adder_z_ack;
        t_o = !rst && output_sum_stb && output_sum_ack;

        if (rst_check) begin
            check("post_rst_stb_ack",
                  64'({input_x_ack, adder_a_stb, adder_b_stb, adder_z_ack, output_sum_stb}), 64'd0);
            check("post_rst_data", {adder_a, adder_b}, 64'd0);
            check("post_rst_sum", 64'(output_sum), 64'd0);
            rst_check = 1'b0;
        end
        check("a_b_exclusive", 64'(adder_a_stb & adder_b_stb), 64'd0);
        if (exp_out_q.size() > 0) check("x_ack_low_at_frame_end", 64'(input_x_ack), 64'd0);
        if (p_valid && p_a_stb && !p_t_a) check("a_hold", {31'd0, adder_a_stb, adder_a}, {31'd0, 1'b1, p_a});
        if (p_valid && p_b_stb && !p_t_b) check("b_hold", {31'd0, adder_b_stb, adder_b}, {31'd0, 1'b1, p_b});
        if (p_valid && p_o_stb && !p_t_o) check("sum_hold", {31'd0, output_sum_stb, output_sum}, {31'd0, 1'b1, p_o});

        if (t_x) begin
            op_a_q.push_back(m_nan ? QNAN : r2f(m_sum));
            op_b_q.push_back(input_x);
            if (is_nan(input_x)) m_nan = 1'b1;
            else m_sum = m_sum + f2r(input_x);
            m_n++;
            if (m_n == LEN) begin
                exp_out_q.push_back(m_nan ? QNAN : r2f(m_sum));
                m_sum = 0.0; m_nan = 1'b0; m_n = 0;
            end
            void'(feed_q.pop_front());
        end
        if (t_a) begin
            if (op_a_q.size() == 0) check("a_unexpected", 64'd1, 64'd0);
            else check("adder_a", 64'(adder_a), 64'(op_a_q.pop_front()));
            if (lit_a_q.size() > 0) check("adder_a_literal", 64'(adder_a), 64'(lit_a_q.pop_front()));
            em_a = adder_a;
        end
        if (t_b) begin
            if (op_b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else check("adder_b", 64'(adder_b), 64'(op_b_q.pop_front()));
            em_z = (is_nan(em_a) || is_nan(adder_b)) ? QNAN : r2f(f2r(em_a) + f2r(adder_b));
            em_have_z = 1'b1;
            em_lat = $urandom_range(0, 3);
        end
        if (t_z) em_have_z = 1'b0;
        if (t_o) begin
            if (exp_out_q.size() == 0) check("sum_unexpected", 64'd1, 64'd0);
            else check("output_sum", 64'(output_sum), 64'(exp_out_q.pop_front()));
            if (lit_q.size() > 0) check("output_sum_literal", 64'(output_sum), 64'(lit_q.pop_front()));
            n_out++;
        end
        if (saw_rst) begin
            m_sum = 0.0; m_nan = 1'b0; m_n = 0;
            op_a_q.delete(); op_b_q.delete(); exp_out_q.delete(); feed_q.delete();
            em_have_z = 1'b0;
            rst_check = 1'b1;
        end
        p_valid = !saw_rst;
        p_a_stb = adder_a_stb; p_b_stb = adder_b_stb; p_o_stb = output_sum_stb;
        p_t_a = t_a; p_t_b = t_b; p_t_o = t_o;
        p_a = adder_a; p_b = adder_b; p_o = output_sum;

        @(posedge clk);
        #1;
        rst = rst_req;
        rst_req = 1'b0;
        if (t_x || saw_rst) input_x_stb = 1'b0;
        if (!input_x_stb && feed_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            input_x_stb = 1'b1;
            input_x = feed_q[0];
        end
        adder_a_ack = 1'($urandom_range(0, 1));
        adder_b_ack = 1'($urandom_range(0, 1));
        if (t_z || saw_rst) adder_z_stb = 1'b0;
        if (em_have_z && !adder_z_stb) begin
            if (em_lat > 0) em_lat--;
            else begin
                adder_z_stb = 1'b1;
                adder_z = em_z;
            end
        end
        if (output_sum_stb && hold_out > 0) begin
            hold_out--;
            output_sum_ack = 1'b0;
        end else begin
            output_sum_ack = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic feed4(input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
        feed_q.push_back(s0); feed_q.push_back(s1);
        feed_q.push_back(s2); feed_q.push_back(s3);
    endtask

    task automatic run_outputs(input string name, input int n, input int budget);
        int start;
        start = n_out;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_out >= start + n) break;
        end
        check(name, 64'(n_out), 64'(start + n));
    endtask

    initial begin
        rst = 1'b1;
        input_x = 32'd0; input_x_stb = 1'b0;
        adder_a_ack = 1'b0; adder_b_ack = 1'b0;
        adder_z = 32'd0; adder_z_stb = 1'b0;
        output_sum_ack = 1'b0;

        rst_req = 1'b1; step();
        rst_req = 1'b1; step();
        step();
        step();

        feed4(32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        lit_q.push_back(32'h4120_0000);
        run_outputs("frame_1234_done", 1, 600);

        for (int i = 0; i < 8; i++) feed_q.push_back(32'h3f80_0000);
        lit_q.push_back(32'h4080_0000); lit_q.push_back(32'h4080_0000);
        run_outputs("back_to_back_done", 2, 1200);

        feed4(32'h40a0_0000, 32'hc0a0_0000, 32'h3fc0_0000, 32'h0000_0000);
        lit_q.push_back(32'h3fc0_0000);
        lit_a_q.push_back(32'h0000_0000); lit_a_q.push_back(32'h40a0_0000);
        lit_a_q.push_back(32'h0000_0000); lit_a_q.push_back(32'h3fc0_0000);
        run_outputs("sign_cancel_done", 1, 600);

        hold_out = 20;
        feed4(32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        lit_q.push_back(32'h4120_0000);
        run_outputs("backpressure_done", 1, 600);
        check("backpressure_hold_used", 64'(hold_out), 64'd0);

        feed4(32'h3f80_0000, 32'h7fc0_0000, 32'h3f80_0000, 32'h3f80_0000);
        lit_q.push_back(QNAN);
        run_outputs("nan_done", 1, 600);

        feed4(32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000);
        for (int i = 0; i < 400 && m_n < 2; i++) step();
        check("mid_frame_reached", 64'(m_n), 64'd2);
        rst_req = 1'b1; step();
        step();
        step();
        feed4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        lit_q.push_back(32'h4100_0000);
        run_outputs("after_reset_done", 1, 600);

        for (int i = 0; i < 10 * LEN; i++) begin
            int k;
            k = $urandom_range(0, 32);
            feed_q.push_back(r2f(real'(k - 16) / 2.0));
        end
        run_outputs("random_frames_done", 10, 8000);

        check("leftover_outputs", 64'(exp_out_q.size()), 64'd0);
        check("leftover_operands", 64'(op_a_q.size() + op_b_q.size()), 64'd0);
        check("literals_consumed", 64'(lit_q.size() + lit_a_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
